bcd_mod_counter: RTL
====================

BCD_MOD_COUNTER -- requirements
Module: bcd_mod_counter

Interface
REQ-001 Parameter MODULUS, default 60: count range 0..MODULUS-1; legal range 2..10**DIGITS.
REQ-002 Parameter DIGITS, default 2: number of BCD digits; legal range 1..4.
REQ-003 CP  input  1: the single clock; all state changes on its rising edge.
REQ-004 CR  input  1: asynchronous, active-high reset.
REQ-005 EN  input  1: count enable.
REQ-006 UP  input  1: direction; 1 = count up, 0 = count down.
REQ-007 LD  input  1: synchronous load strobe.
REQ-008 D  input  4*DIGITS: BCD load value; digit 0 in bits [3:0].
REQ-009 Q  output  4*DIGITS: current count, BCD; digit 0 in bits [3:0].
REQ-010 CO  output  1: cascade carry/borrow, combinational.
REQ-011 ERR  output  1: registered one-cycle flag for a rejected load.

Function
REQ-012 Q SHALL always hold a valid BCD value in 0..MODULUS-1.
REQ-013 Priority per edge SHALL be CR > LD > EN; EN=0 and LD=0 holds Q.
REQ-014 Up count SHALL add 1 with per-digit decimal carry (digit 9 -> 0, carry into the next digit), and wrap MODULUS-1 -> 0.
REQ-015 Down count SHALL subtract 1 with per-digit decimal borrow (digit 0 -> 9, borrow from the next digit), and wrap 0 -> MODULUS-1 in BCD.
REQ-016 CO SHALL equal EN & ~LD & (UP ? Q==MODULUS-1 : Q==0), so counters chained by CO->EN advance in the same cycle as the wrap.
REQ-017 Latency: Q SHALL reflect a count or load on the same rising edge on which EN or LD is sampled.
REQ-018 Load SHALL accept D only if every digit is <=9 and the decoded value is <MODULUS.
REQ-019 A rejected load SHALL set Q to 0 and assert ERR for exactly the following cycle.
REQ-020 ERR SHALL be 0 in every cycle not immediately following a rejected load; back-to-back rejected loads keep ERR high.
REQ-021 LD with EN=1 SHALL load only; no count is applied in that cycle.
REQ-022 A UP change takes effect on the next enabled edge and does not alter Q by itself.
REQ-023 With MODULUS=10**DIGITS, wrap SHALL follow the natural BCD roll-over (e.g. 99 -> 00).

Reset
REQ-024 CR=1 SHALL immediately, without waiting for CP, force Q=0 and ERR=0.
REQ-025 CO SHALL follow REQ-016 during reset (Q=0): CO = EN & ~LD & ~UP.
REQ-026 Reset asserted mid-count or mid-load SHALL discard the operation; after release, the first CP edge evaluates from Q=0.
REQ-027 Release of CR is expected to be synchronous to CP; no internal synchroniser.

Structure
REQ-028 The shared clock package SHALL hold the BCD digit width (4), the max-digit constant (9), and the BCD-to-binary and binary-to-BCD constant functions used to derive MODULUS-1 in BCD.
REQ-029 One sub-module bcd_digit SHALL provide single-digit increment/decrement with carry-in/carry-out; the top instantiates DIGITS of them in a generate loop.
REQ-030 Load validation and terminal-count compare SHALL live in the top level.

Verification
REQ-031 Default params, CR=1 for 100 ns then 0, EN=1, UP=1, CP period 20 ns -> Q steps 00..59, 00; CO high only while Q=59.
REQ-032 UP=0 from Q=00 -> Q=59, 58, ... 50, 49; CO high only while Q=00.
REQ-033 LD=1, D=8'h45, EN=1 -> Q=45 next edge, no increment; then LD=0 -> 46.
REQ-034 Rejected loads: LD with D=8'h7A, then LD with D=8'h60 -> Q=00 after each; ERR high for two consecutive cycles, then low.
REQ-035 CR pulsed between edges while Q=37 -> Q=00 before the next CP edge; first count after release gives 01.
REQ-036 MODULUS=24, DIGITS=2, chained with a MODULUS=60 instance via CO->EN -> 23:59 -> 00:00 on one edge.

Source files
------------

// File: rtl/bcd_mod_counter_pkg.sv
// Shared constants and constant functions for the BCD modulo counter.
// A BCD bus here is at most four digits wide, and digit 0 sits in bits [3:0].
package bcd_mod_counter_pkg;

    localparam int BCD_W      = 4;
    localparam int BCD_MAX    = 9;
    localparam int MAX_DIGITS = 4;
    localparam int BCD_BUS_W  = BCD_W * MAX_DIGITS;

    // Packed BCD converted to binary; assumes every digit is already 0..9.
    function automatic int unsigned bcd2bin(input logic [BCD_BUS_W-1:0] bcd);
        int unsigned acc;
        acc = 32'd0;
        for (int i = MAX_DIGITS - 1; i >= 0; i--) begin
            acc = acc * 32'd10 + 32'(bcd[i*BCD_W +: BCD_W]);
        end
        return acc;
    endfunction

    // Binary converted to packed BCD, four digits.
    function automatic logic [BCD_BUS_W-1:0] bin2bcd(input int unsigned value);
        logic [BCD_BUS_W-1:0] bcd;
        int unsigned          rem;
        bcd = '0;
        rem = value;
        for (int i = 0; i < MAX_DIGITS; i++) begin
            bcd[i*BCD_W +: BCD_W] = 4'(rem % 32'd10);
            rem                   = rem / 32'd10;
        end
        return bcd;
    endfunction

endpackage

// File: rtl/bcd_mod_counter_digit.sv
// Single BCD digit step: increment or decrement by carry-in, with decimal carry/borrow out.
// The module is named bcd_digit and is instantiated once per digit by bcd_mod_counter.
module bcd_digit
    import bcd_mod_counter_pkg::*;
(
    input  logic [BCD_W-1:0] digit_i,
    input  logic             up_i,
    input  logic             cin_i,
    output logic [BCD_W-1:0] digit_o,
    output logic             cout_o
);

    // A digit moves only when every lower digit rolls over, which is what cin_i signals.
    always_comb begin
        digit_o = digit_i;
        cout_o  = 1'b0;
        if (!cin_i) begin
            digit_o = digit_i;
            cout_o  = 1'b0;
        end else if (up_i) begin
            if (digit_i >= 4'(BCD_MAX)) begin
                digit_o = 4'd0;
                cout_o  = 1'b1;
            end else begin
                digit_o = digit_i + 4'd1;
                cout_o  = 1'b0;
            end
        end else begin
            if (digit_i == 4'd0) begin
                digit_o = 4'(BCD_MAX);
                cout_o  = 1'b1;
            end else begin
                digit_o = digit_i - 4'd1;
                cout_o  = 1'b0;
            end
        end
    end

endmodule

// File: rtl/bcd_mod_counter.sv
// Up/down BCD counter modulo MODULUS with validated synchronous load and a cascade carry.
// CO is combinational so that a chained counter advances on the same edge as the wrap.
module bcd_mod_counter
    import bcd_mod_counter_pkg::*;
#(
    parameter int MODULUS = 60,
    parameter int DIGITS  = 2
) (
    input  logic                    CP,
    input  logic                    CR,
    input  logic                    EN,
    input  logic                    UP,
    input  logic                    LD,
    input  logic [BCD_W*DIGITS-1:0] D,
    output logic [BCD_W*DIGITS-1:0] Q,
    output logic                    CO,
    output logic                    ERR
);

    localparam int                    W         = BCD_W * DIGITS;
    localparam logic [BCD_BUS_W-1:0]  TERM_FULL = bin2bcd(32'(MODULUS - 1));
    localparam logic [W-1:0]          TERM_BCD  = TERM_FULL[W-1:0];
    localparam int unsigned           MOD_U     = 32'(MODULUS);

    logic [W-1:0]         q_q;
    logic [W-1:0]         q_d;
    logic                 err_q;
    logic                 err_d;
    logic [W-1:0]         step_s;
    logic [DIGITS:0]      carry_s;
    logic [BCD_BUS_W-1:0] d_pad_s;
    logic                 digits_ok_s;
    logic                 load_ok_s;
    logic                 at_max_s;
    logic                 at_zero_s;
    logic                 at_term_s;
    logic                 wrap_s;

    assign carry_s[0] = 1'b1;

    generate
        for (genvar g = 0; g < DIGITS; g++) begin : g_digit
            bcd_digit u_digit (
                .digit_i (q_q[g*BCD_W +: BCD_W]),
                .up_i    (UP),
                .cin_i   (carry_s[g]),
                .digit_o (step_s[g*BCD_W +: BCD_W]),
                .cout_o  (carry_s[g+1])
            );
        end
    endgenerate

    // Load value is accepted only if each digit is decimal and the value is in range.
    always_comb begin
        d_pad_s        = '0;
        d_pad_s[W-1:0] = D;
        digits_ok_s    = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (D[i*BCD_W +: BCD_W] > 4'(BCD_MAX)) begin
                digits_ok_s = 1'b0;
            end else begin
                digits_ok_s = digits_ok_s;
            end
        end
        load_ok_s = digits_ok_s && (bcd2bin(d_pad_s) < MOD_U);
    end

    assign at_max_s  = (q_q == TERM_BCD);
    assign at_zero_s = (q_q == '0);
    assign at_term_s = UP ? at_max_s : at_zero_s;
    // Carry out of the top digit implies the terminal count anyway; folding it in is harmless.
    assign wrap_s    = at_term_s | carry_s[DIGITS];
    assign CO        = EN & ~LD & at_term_s;

    // Next-state selection: load beats count, and a held count keeps its value.
    always_comb begin
        q_d   = q_q;
        err_d = 1'b0;
        if (LD) begin
            if (load_ok_s) begin
                q_d   = D;
                err_d = 1'b0;
            end else begin
                q_d   = '0;
                err_d = 1'b1;
            end
        end else if (EN) begin
            if (wrap_s) begin
                q_d = UP ? '0 : TERM_BCD;
            end else begin
                q_d = step_s;
            end
        end else begin
            q_d = q_q;
        end
    end

    // Count and error-flag registers, cleared asynchronously by CR.
    always_ff @(posedge CP or posedge CR) begin
        if (CR) begin
            q_q   <= '0;
            err_q <= 1'b0;
        end else begin
            q_q   <= q_d;
            err_q <= err_d;
        end
    end

    assign Q   = q_q;
    assign ERR = err_q;

endmodule
